// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and voter helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_BREAK,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    localparam int UART_CLK_PER_BIT     = 100;
    localparam int UART_CLK_PER_BIT_3_2 = (UART_CLK_PER_BIT * 3) / 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_pop;
    logic             w_push;

    assign empty    = (r_fill == '0);
    assign full     = (r_fill == FILL_MAX);
    assign fill     = r_fill;
    assign pop_data = r_mem[r_rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
            else if (w_pop && !w_push) r_fill <= r_fill - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with majority-vote sampling feeding a byte FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        RX,
    output logic [7:0]                  data,
    output logic                        valid,
    input  logic                        ready,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fill
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_smp;
    logic          r_frame_err;
    logic          r_overrun;
    logic          w_rx_s;
    logic          w_cnt_zero;
    logic          w_bit;
    logic          w_push;
    logic          w_ferr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    assign w_rx_s     = r_sync[1];
    assign w_cnt_zero = (r_cnt == '0);
    assign w_bit      = maj3(r_smp[1], r_smp[0], w_rx_s);
    assign w_pop      = valid && ready;
    assign valid      = !w_empty;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_BREAK: if (w_rx_s) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (!w_rx_s) w_state_nxt = ST_START;
            ST_START: if (w_cnt_zero) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_cnt_zero && r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
            ST_STOP: begin
                // Leaving at the stop-bit centre lets a following frame start with no gap.
                if (w_cnt_zero) begin
                    if (w_bit) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            default: w_state_nxt = ST_BREAK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= ST_BREAK;
            r_sync      <= 2'b11;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_smp       <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync      <= {r_sync[0], RX};
            r_frame_err <= w_ferr;
            r_overrun   <= w_push && w_full && !w_pop;
            case (r_state)
                ST_IDLE: r_cnt <= CNT_HALF;
                ST_START: begin
                    if (w_cnt_zero) begin
                        r_cnt     <= CNT_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DATA, ST_STOP: begin
                    if (r_cnt == CW'(2)) r_smp[1] <= w_rx_s;
                    if (r_cnt == CW'(1)) r_smp[0] <= w_rx_s;
                    if (w_cnt_zero) begin
                        r_cnt <= CNT_FULL;
                        if (r_state == ST_DATA) begin
                            r_shift   <= {w_bit, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .resetn    (RESET_N),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (w_pop),
        .pop_data  (data),
        .full      (w_full),
        .empty     (w_empty),
        .fill      (fill)
    );

endmodule
